// File: rtl/audio_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// audio_fetch_scheduler
// Per-frame sample fetch scheduler. A frame strobe latches the playing-channel
// set; the block then issues one AXI-Lite read per latched channel in ascending
// index order, one read outstanding at a time. Each returned word is presented
// on smp_data together with a one-cycle one-hot smp_load pulse for its channel.
//
// Optional build macro: AUDIO_FETCH_ERRCNT_EN
//   defined   : adds err_count output; error beats (rresp != OKAY) deliver 0
//               and bump a saturating counter.
//   undefined : rresp ignored, rdata passed through unchanged.
//
// Ports
//   aclk, aresetn      clock / synchronous active-low reset
//   frame_strobe       1-cycle frame start pulse
//   ch_active          channel play flags, latched at frame start
//   ch_addr            per-channel sample address, ch i at [i*ADDR_W +: ADDR_W]
//   m_axil_ar*/r*      AXI-Lite read master (address + data channels)
//   smp_data/smp_load  fetched sample and one-hot load pulse
//   busy               high whenever a frame is in progress
//   frame_done         1-cycle pulse when a frame completes
//   overrun/_clr       sticky "strobe while busy" flag and its clear
//   err_count          (AUDIO_FETCH_ERRCNT_EN only) saturating error counter
// -----------------------------------------------------------------------------
module audio_fetch_scheduler #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     frame_strobe,
  input  logic [NUM_CH-1:0]        ch_active,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [ADDR_W-1:0]        m_axil_araddr,
  output logic [2:0]               m_axil_arprot,
  output logic                     m_axil_arvalid,
  input  logic                     m_axil_arready,
  input  logic [DATA_W-1:0]        m_axil_rdata,
  input  logic [1:0]               m_axil_rresp,
  input  logic                     m_axil_rvalid,
  output logic                     m_axil_rready,
  output logic [DATA_W-1:0]        smp_data,
  output logic [NUM_CH-1:0]        smp_load,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  input  logic                     overrun_clr
`ifdef AUDIO_FETCH_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]      err_count
`endif
);

  localparam int unsigned CUR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_ADDR, S_DATA} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [CUR_W-1:0]    cur_q, cur_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [DATA_W-1:0]   smp_data_q, smp_data_d;
  logic [NUM_CH-1:0]   smp_load_q, smp_load_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  logic [CUR_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   beat_data;
  logic [ADDR_W-1:0]   addr_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_addr
    assign addr_arr[g] = ch_addr[g*ADDR_W +: ADDR_W];
  end

  // Lowest set bit of pending: scan downward so the last hit is the lowest.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = CUR_W'(i);
    end
  end

`ifdef AUDIO_FETCH_ERRCNT_EN
  logic                beat_err;
  logic [ERRCNT_W-1:0] err_q, err_d;

  assign beat_err  = (m_axil_rresp != 2'b00);
  assign beat_data = beat_err ? '0 : m_axil_rdata;

  always_comb begin
    err_d = err_q;
    if (state_q == S_DATA && m_axil_rvalid && rready_q && beat_err && (err_q != '1))
      err_d = err_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err_count = err_q;
`else
  localparam int unsigned unused_errcnt_w = ERRCNT_W;
  logic unused_rresp;
  assign unused_rresp = &{1'b0, m_axil_rresp};
  assign beat_data    = m_axil_rdata;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cur_d      = cur_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    smp_data_d = smp_data_q;
    smp_load_d = '0;
    done_d     = 1'b0;

    // Clear first so a coincident set wins.
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (frame_strobe && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_strobe) begin
          pending_d = ch_active;
          if (ch_active != '0) state_d = S_SEL;
          else                 done_d  = 1'b1;
        end
      end
      S_SEL: begin
        cur_d     = sel_idx;
        araddr_d  = addr_arr[sel_idx];
        arvalid_d = 1'b1;
        state_d   = S_ADDR;
      end
      S_ADDR: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (m_axil_rvalid && rready_q) begin
          smp_data_d        = beat_data;
          smp_load_d[cur_q] = 1'b1;
          pending_d[cur_q]  = 1'b0;
          rready_d          = 1'b0;
          if (pending_d != '0) begin
            state_d = S_SEL;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      cur_q      <= '0;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      smp_data_q <= '0;
      smp_load_q <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cur_q      <= cur_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      smp_data_q <= smp_data_d;
      smp_load_q <= smp_load_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign smp_data       = smp_data_q;
  assign smp_load       = smp_load_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = done_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_audio_fetch_scheduler.sv
// Bench for audio_fetch_scheduler: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a queue-based
// frame model.
module tb_audio_fetch_scheduler;
  localparam int NCH = 8;
  localparam int AW  = 32;
  localparam int DW  = 16;
`ifdef AUDIO_FETCH_ERRCNT_EN
  localparam int EW  = 4;
`else
  localparam int EW  = 16;
`endif

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              frame_strobe = 1'b0;
  logic [NCH-1:0]    ch_active = '0;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic              arready = 1'b0;
  logic [DW-1:0]     rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rvalid = 1'b0;
  logic              overrun_clr = 1'b0;

  logic [AW-1:0]     araddr;
  logic [2:0]        arprot;
  logic              arvalid, rready;
  logic [DW-1:0]     smp_data;
  logic [NCH-1:0]    smp_load;
  logic              busy, frame_done, overrun;
`ifdef AUDIO_FETCH_ERRCNT_EN
  logic [EW-1:0]     err_count;
`endif

  audio_fetch_scheduler #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .ERRCNT_W(EW)) dut (
    .aclk(aclk), .aresetn(aresetn), .frame_strobe(frame_strobe),
    .ch_active(ch_active), .ch_addr(ch_addr),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
    .m_axil_rvalid(rvalid), .m_axil_rready(rready),
    .smp_data(smp_data), .smp_load(smp_load), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef AUDIO_FETCH_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return ch_addr[i*AW +: AW];
  endfunction

  // ---------------------------------------------------------------------------
  // Frame model: the queue holds the channels still to be served this frame.
  // Each channel walks through: one select cycle, address offered until
  // accepted, data accepted when rvalid shows up.
  // ---------------------------------------------------------------------------
  int             q[$];
  bit             m_valid = 1'b0;
  bit             m_busy;
  int             m_phase;
  logic [AW-1:0]  m_araddr;
  bit             m_arv, m_rr, m_done, m_ovr, m_bad;
  logic [DW-1:0]  m_smp;
  logic [NCH-1:0] m_load;
  int             m_err;

  always @(negedge aclk) begin
    if (m_valid) begin
      chk("araddr", araddr, m_araddr);
      chk("arvalid", arvalid, m_arv);
      chk("arprot", arprot, 3'b000);
      chk("rready", rready, m_rr);
      chk("smp_data", smp_data, m_smp);
      chk("smp_load", smp_load, m_load);
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, m_done);
      chk("overrun", overrun, m_ovr);
`ifdef AUDIO_FETCH_ERRCNT_EN
      chk("err_count", err_count, m_err);
`endif
    end

    if (!aresetn) begin
      q.delete();
      m_busy = 0; m_phase = 0; m_araddr = '0; m_arv = 0; m_rr = 0;
      m_smp = '0; m_load = '0; m_done = 0; m_ovr = 0; m_err = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_load = '0;
      m_done = 0;
      if (frame_strobe && m_busy) m_ovr = 1;
      else if (overrun_clr)       m_ovr = 0;
      if (!m_busy) begin
        if (frame_strobe) begin
          for (int i = 0; i < NCH; i++) if (ch_active[i]) q.push_back(i);
          if (q.size() == 0) m_done = 1;
          else begin m_busy = 1; m_phase = 0; end
        end
      end else if (m_phase == 0) begin
        m_araddr = addr_of(q[0]);
        m_arv    = 1;
        m_phase  = 1;
      end else if (m_phase == 1) begin
        if (arready) begin m_arv = 0; m_rr = 1; m_phase = 2; end
      end else if (rvalid) begin
`ifdef AUDIO_FETCH_ERRCNT_EN
        m_bad = (rresp != 2'b00);
`else
        m_bad = 0;
`endif
        m_smp = m_bad ? '0 : rdata;
        if (m_bad && m_err < (1 << EW) - 1) m_err++;
        m_load[q[0]] = 1'b1;
        m_rr = 0;
        void'(q.pop_front());
        if (q.size() == 0) begin m_busy = 0; m_done = 1; end
        else m_phase = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] loads[$];
  logic [NCH-1:0] exp_l [4];
  int  done_at, first_arv, nloads;
  bit  flag, flag2, got;
  bit  ovr5;

  initial begin
    for (int i = 0; i < NCH; i++) ch_addr[i*AW +: AW] = 32'h1000_0000 + 32'h100 * i;
    step(); step(); step();
    // Reset state
    chk("rst_araddr", araddr, '0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_smp_data", smp_data, '0);
    chk("rst_smp_load", smp_load, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    aresetn = 1'b1;
    step();

    // 1: four channels, zero-wait slave
    arready = 1; rvalid = 1; rdata = 16'hBEEF;
    ch_active = 8'b1010_0101; frame_strobe = 1; step(); frame_strobe = 0;
    done_at = -1; first_arv = -1; loads.delete();
    for (int n = 1; n <= 30; n++) begin
      if (smp_load != 0) loads.push_back(smp_load);
      if (frame_done && done_at < 0) done_at = n;
      if (arvalid && first_arv < 0) first_arv = n;
      step();
    end
    exp_l = '{8'h01, 8'h04, 8'h20, 8'h80};
    chk("t1_first_arvalid_cycle", first_arv, 2);
    chk("t1_frame_done_cycle", done_at, 13);
    chk("t1_num_loads", loads.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < loads.size()) chk("t1_load_order", loads[i], exp_l[i]);

    // 2: empty frame
    ch_active = '0; frame_strobe = 1; step(); frame_strobe = 0;
    chk("t2_done_next_cycle", frame_done, 1);
    flag = 0;
    for (int n = 0; n < 5; n++) begin
      if (busy || arvalid) flag = 1;
      step();
    end
    chk("t2_never_busy", flag, 0);

    // 3: address stall on ch3
    ch_active = 8'h08; arready = 0; rvalid = 0; rdata = 16'h1234;
    frame_strobe = 1; step(); frame_strobe = 0; step();
    flag = 1;
    for (int k = 0; k < 5; k++) begin
      if (!(arvalid === 1'b1 && araddr === addr_of(3))) flag = 0;
      step();
    end
    chk("t3_ar_stable", flag, 1);
    arready = 1; step(); arready = 0;
    flag = 0;
    for (int k = 0; k < 2; k++) begin
      if (smp_load != 0) flag = 1;
      step();
    end
    chk("t3_no_early_load", flag, 0);
    rvalid = 1; step(); rvalid = 0;
    chk("t3_load", smp_load, 8'h08);
    chk("t3_data", smp_data, 16'h1234);
    step(); step();

    // 4: overrun
    arready = 1; rvalid = 1; rdata = 16'h5555; ch_active = 8'hFF;
    frame_strobe = 1; step(); frame_strobe = 0;
    done_at = -1; nloads = 0; ovr5 = 0;
    for (int n = 1; n <= 40; n++) begin
      if (smp_load != 0) nloads++;
      if (frame_done && done_at < 0) done_at = n;
      if (n == 5) ovr5 = overrun;
      frame_strobe = (n == 4);
      step();
    end
    frame_strobe = 0;
    chk("t4_overrun_set", ovr5, 1);
    chk("t4_no_restart_done", done_at, 25);
    chk("t4_no_restart_loads", nloads, 8);
    overrun_clr = 1; step(); overrun_clr = 0;
    chk("t4_overrun_clr", overrun, 0);
    ch_active = 8'h01; frame_strobe = 1; step();
    overrun_clr = 1; step(); frame_strobe = 0; overrun_clr = 0;
    chk("t4_set_wins", overrun, 1);
    for (int k = 0; k < 6; k++) step();
    overrun_clr = 1; step(); overrun_clr = 0;

    // 5: reset during DATA
    arready = 1; rvalid = 0; ch_active = 8'h06;
    frame_strobe = 1; step(); frame_strobe = 0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (rready) got = 1;
      else step();
    end
    chk("t5_reached_data", got, 1);
    aresetn = 0; step(); aresetn = 1;
    chk("t5_arvalid", arvalid, 0);
    chk("t5_rready", rready, 0);
    chk("t5_smp_load", smp_load, '0);
    chk("t5_busy", busy, 0);
    rvalid = 1;
    flag = 0; flag2 = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy || arvalid) flag = 1;
      if (smp_load != 0 || frame_done) flag2 = 1;
      step();
    end
    chk("t5_pending_cleared", flag, 0);
    chk("t5_no_stale_beat", flag2, 0);

`ifdef AUDIO_FETCH_ERRCNT_EN
    // 6: error responses
    arready = 1; rvalid = 1; rdata = 16'h7FFF; rresp = 2'b10; ch_active = 8'h02;
    frame_strobe = 1; step(); frame_strobe = 0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (smp_load != 0) got = 1;
      else step();
    end
    chk("t6_load_seen", got, 1);
    chk("t6_load", smp_load, 8'h02);
    chk("t6_data_zeroed", smp_data, 16'h0000);
    chk("t6_err_count", err_count, 1);
    ch_active = 8'hFF;
    for (int f = 0; f < 2; f++) begin
      frame_strobe = 1; step(); frame_strobe = 0;
      for (int k = 0; k < 28; k++) step();
    end
    chk("t6_err_saturated", err_count, (1 << EW) - 1);
    rresp = 2'b00;
    aresetn = 0; step(); aresetn = 1; step();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      arready      = ($urandom % 4) != 0;
      rvalid       = ($urandom % 3) != 0;
      rdata        = DW'($urandom);
      rresp        = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
      frame_strobe = ($urandom % 20) == 0;
      ch_active    = (($urandom % 8) == 0) ? '0 : NCH'($urandom);
      overrun_clr  = ($urandom % 15) == 0;
      aresetn      = ($urandom % 400) != 0;
      if (($urandom % 10) == 0) ch_addr[($urandom % NCH)*AW +: AW] = $urandom;
      step();
    end
    frame_strobe = 0; overrun_clr = 0; aresetn = 1; arready = 1; rvalid = 1; rresp = 0;
    for (int k = 0; k < 40; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
